// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the loader FSM state type and the helpers that derive packer and
// counter widths from the module parameters.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        COLLECT,
        WRITE,
        CHK,
        DONE
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_NUM_WORDS = 32;

    // BYTES_PER_WORD for a given instruction width.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    // Byte-count and word-index width: wide enough to hold NUM_WORDS itself.
    function automatic int cnt_bits(input int num_words);
        return $clog2(num_words) + 1;
    endfunction

endpackage

// File: rtl/instr_byte_packer.sv
// Byte packer for the instruction loader.
// Shifts stream bytes big-endian into a word, counts bytes of the current
// word and keeps a running XOR of every byte shifted in since clear.
//   clear     : zero shift register, byte count and checksum
//   restart   : zero byte count only (start of the next word)
//   shift     : accept byte_in
//   word      : assembled word including byte_in (valid with word_full)
//   word_full : this shift completes the word
//   checksum  : XOR of all bytes shifted since clear
module instr_byte_packer
    import instr_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             restart,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             word_full,
    output logic [7:0]       checksum
);

    localparam int BPW = bytes_per_word(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] count;

    // Expose the word as it will look after this shift so the loader can
    // register it into the write port on the same edge as the last byte.
    assign word      = WIDTH'({sreg, byte_in});
    assign word_full = shift && (count == CNT_W'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            count    <= '0;
            checksum <= '0;
        end else if (clear) begin
            sreg     <= '0;
            count    <= '0;
            checksum <= '0;
        end else begin
            if (restart)
                count <= '0;
            if (shift) begin
                sreg     <= word;
                checksum <= checksum ^ byte_in;
                count    <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction memory loader.
// Receives a framed byte stream (header N, N words MSB first, XOR checksum)
// over valid/ready, writes each word to sequential addresses from 0 and
// reports completion or a framing/checksum error.
//   start              : begin a frame (IDLE only)
//   byte_valid/byte_in : stream byte offered
//   byte_ready         : loader takes byte_in this cycle
//   write_valid/adr/instr_data : memory write port, registered
//   busy  : load in progress
//   done  : one-cycle pulse on a good frame
//   error : sticky bad header / bad checksum, cleared by the next start
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int WIDTH               = DEF_WIDTH,
    parameter int INSTR_MEM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int NUM_WORDS           = DEF_NUM_WORDS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_in,
    output logic                           byte_ready,
    output logic                           write_valid,
    output logic [INSTR_MEM_ADDR_BITS-1:0] write_adr,
    output logic [WIDTH-1:0]               instr_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int IDX_W = cnt_bits(NUM_WORDS);

    state_t           state, state_n;
    logic [IDX_W-1:0] n_words, idx;
    logic             xfer;
    logic             pk_clear, pk_restart, pk_shift, pk_full;
    logic [WIDTH-1:0] pk_word;
    logic [7:0]       pk_chk;
    logic             n_load, idx_inc, err_set, err_clr;

    // byte_ready is registered from the state, so it always matches state.
    assign xfer = byte_valid && byte_ready;

    instr_byte_packer #(
        .WIDTH (WIDTH),
        .CNT_W (IDX_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .restart   (pk_restart),
        .shift     (pk_shift),
        .byte_in   (byte_in),
        .word      (pk_word),
        .word_full (pk_full),
        .checksum  (pk_chk)
    );

    always_comb begin
        state_n    = state;
        pk_clear   = 1'b0;
        pk_restart = 1'b0;
        pk_shift   = 1'b0;
        n_load     = 1'b0;
        idx_inc    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    err_clr = 1'b1;
                    state_n = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (byte_in == 8'd0 || 32'(byte_in) > 32'(NUM_WORDS)) begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end else begin
                        n_load   = 1'b1;
                        pk_clear = 1'b1;
                        state_n  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    pk_shift = 1'b1;
                    if (pk_full)
                        state_n = WRITE;
                end
            end
            WRITE: begin
                if (idx == n_words - IDX_W'(1)) begin
                    state_n = CHK;
                end else begin
                    idx_inc    = 1'b1;
                    pk_restart = 1'b1;
                    state_n    = COLLECT;
                end
            end
            CHK: begin
                if (xfer) begin
                    if (byte_in == pk_chk) begin
                        state_n = DONE;
                    end else begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // All outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n_words     <= '0;
            idx         <= '0;
            byte_ready  <= 1'b0;
            write_valid <= 1'b0;
            write_adr   <= '0;
            instr_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            byte_ready  <= (state_n == HDR) || (state_n == COLLECT) || (state_n == CHK);
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
            write_valid <= (state_n == WRITE);
            if (state_n == WRITE) begin
                write_adr  <= INSTR_MEM_ADDR_BITS'(idx);
                instr_data <= pk_word;
            end
            if (n_load) begin
                n_words <= IDX_W'(byte_in);
                idx     <= '0;
            end
            if (idx_inc)
                idx <= idx + IDX_W'(1);
            if (err_set)
                error <= 1'b1;
            else if (err_clr)
                error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
    localparam int WIDTH = 32;
    localparam int AW    = 32;
    localparam int NW    = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_ready, write_valid, busy, done, error;
    logic [AW-1:0]    write_adr;
    logic [WIDTH-1:0] instr_data;

    instr_loader #(
        .WIDTH               (WIDTH),
        .INSTR_MEM_ADDR_BITS (AW),
        .NUM_WORDS           (NW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .byte_ready  (byte_ready),
        .write_valid (write_valid),
        .write_adr   (write_adr),
        .instr_data  (instr_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled at negedge like the memory.
    logic [AW-1:0]    wr_adr_q[$];
    logic [WIDTH-1:0] wr_dat_q[$];
    int done_cnt, stall_cnt, bad_rdy;

    always @(negedge clk) begin
        if (!reset) begin
            if (write_valid) begin
                wr_adr_q.push_back(write_adr);
                wr_dat_q.push_back(instr_data);
                if (byte_ready) bad_rdy++;
                if (byte_valid) stall_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clr_mon();
        wr_adr_q.delete();
        wr_dat_q.delete();
        done_cnt  = 0;
        stall_cnt = 0;
        bad_rdy   = 0;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!ok) chk("byte_timeout", 32'(ok), 1);
    endtask

    logic [7:0] stim[$];

    task automatic send_stim(input int max_gap);
        foreach (stim[i])
            send_byte(stim[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic chk_writes(input string tag, input logic [WIDTH-1:0] exp[$]);
        chk({tag, "_nwr"}, 32'(wr_adr_q.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < wr_adr_q.size()) begin
                chk($sformatf("%s_adr%0d", tag, i), wr_adr_q[i], 32'(i));
                chk($sformatf("%s_dat%0d", tag, i), wr_dat_q[i], exp[i]);
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp1[$];
    logic [WIDTH-1:0] exp6[$];
    logic [WIDTH-1:0] none[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp1 = '{32'h8C010004, 32'h00221820};
        none = {};

        // reset state
        #12;
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_wv",    32'(write_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(error), 0);
        chk("rst_adr",   write_adr, 0);
        chk("rst_data",  instr_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: basic two-word frame, back-to-back bytes
        clr_mon();
        do_start();
        chk("t1_busy_hdr", 32'(busy), 1);
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h93};
        send_stim(0);
        settle();
        chk_writes("t1", exp1);
        chk("t1_done",  32'(done_cnt), 1);
        chk("t1_err",   32'(error), 0);
        chk("t1_busy",  32'(busy), 0);
        chk("t1_stall", 32'(stall_cnt > 0), 1);
        chk("t1_rdy_in_wr", 32'(bad_rdy), 0);

        // 2: bad headers, then a good frame clears error
        clr_mon();
        do_start();
        stim = '{8'h00};
        send_stim(0);
        settle();
        chk("t2a_err",   32'(error), 1);
        chk("t2a_busy",  32'(busy), 0);
        chk("t2a_ready", 32'(byte_ready), 0);
        chk("t2a_nwr",   32'(wr_adr_q.size()), 0);
        do_start();
        chk("t2b_err_clr", 32'(error), 0);
        stim = '{8'h21};
        send_stim(0);
        settle();
        chk("t2b_err",   32'(error), 1);
        chk("t2b_busy",  32'(busy), 0);
        chk("t2b_ready", 32'(byte_ready), 0);
        chk("t2b_nwr",   32'(wr_adr_q.size()), 0);
        do_start();
        chk("t2c_err_clr", 32'(error), 0);
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h93};
        send_stim(0);
        settle();
        chk_writes("t2c", exp1);
        chk("t2c_err",  32'(error), 0);
        chk("t2c_done", 32'(done_cnt), 1);

        // 3: bad checksum
        clr_mon();
        do_start();
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h94};
        send_stim(0);
        settle();
        chk_writes("t3", exp1);
        chk("t3_err",  32'(error), 1);
        chk("t3_done", 32'(done_cnt), 0);
        chk("t3_busy", 32'(busy), 0);

        // 4: random valid gaps
        clr_mon();
        do_start();
        chk("t4_err_clr", 32'(error), 0);
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h93};
        send_stim(3);
        settle();
        chk_writes("t4", exp1);
        chk("t4_done", 32'(done_cnt), 1);
        chk("t4_err",  32'(error), 0);
        chk("t4_rdy_in_wr", 32'(bad_rdy), 0);

        // 5: async reset after 2nd byte of word 1
        clr_mon();
        do_start();
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22};
        send_stim(0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ready", 32'(byte_ready), 0);
        chk("t5_wv",    32'(write_valid), 0);
        chk("t5_busy",  32'(busy), 0);
        chk("t5_done",  32'(done), 0);
        chk("t5_err",   32'(error), 0);
        chk("t5_adr",   write_adr, 0);
        chk("t5_data",  instr_data, 0);
        @(negedge clk);
        reset = 1'b0;
        settle();
        chk("t5_nwr", 32'(wr_adr_q.size()), 1);
        clr_mon();
        do_start();
        stim = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20, 8'h93};
        send_stim(0);
        settle();
        chk_writes("t5r", exp1);
        chk("t5r_done", 32'(done_cnt), 1);

        // 6: full-depth frame, checksum of A5,00,00,k over k=0..31 is 00
        clr_mon();
        exp6 = {};
        stim = '{8'h20};
        for (int k = 0; k < NW; k++) begin
            stim.push_back(8'hA5);
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'(k));
            exp6.push_back(32'hA5000000 + 32'(k));
        end
        stim.push_back(8'h00);
        do_start();
        send_stim(0);
        settle();
        chk_writes("t6", exp6);
        if (wr_adr_q.size() > 0)
            chk("t6_last_adr", wr_adr_q[wr_adr_q.size()-1], 31);
        chk("t6_done", 32'(done_cnt), 1);
        chk("t6_err",  32'(error), 0);
        chk("t6_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side front end for the instruction memory. It receives a framed byte stream (a boot or debug link) over a valid/ready handshake.
- It packs the bytes big-endian into WIDTH-bit instructions and drives the memory write port (write_valid, write_adr, write data) at sequential addresses from 0.
- It checks a trailing XOR checksum, and holds the core off via busy for the whole load.

Parameters:
- WIDTH, 32, instruction width in bits; must be a multiple of 8.
- INSTR_MEM_ADDR_BITS, 32, width of write_adr; matches the memory's address width.
- NUM_WORDS, 32, memory depth; maximum words per frame.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a load frame; sampled only in IDLE.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_in  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_in this cycle; a byte transfers when byte_valid && byte_ready.
- write_valid  out  1  one-cycle write strobe to the instruction memory.
- write_adr  out  INSTR_MEM_ADDR_BITS  word address for the write.
- instr_data  out  WIDTH  instruction word to write; drives the memory's instr_in.
- busy  out  1  load in progress; integration gates the core and forces memory en while high.
- done  out  1  one-cycle pulse: frame completed, checksum good.
- error  out  1  sticky: bad header or checksum mismatch; cleared by reset or the next accepted start.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters and checksum 0.
  - Reset during a frame aborts immediately with no further writes.
  - Words already written stay in memory.
- Frame format:
  - Header byte N, where 1 <= N <= NUM_WORDS.
  - Then N*4 data bytes, each word MSB first (first byte -> bits 31:24).
  - Then one checksum byte equal to the XOR of all data bytes; the header is excluded.
- Memory write timing:
  - All outputs are registered on posedge clk.
  - write_valid, write_adr and instr_data are stable across the following negedge, where the memory samples them.
  - write_adr and instr_data hold their last value outside writes.
- FSM states: IDLE, HDR, COLLECT, WRITE, CHK, DONE.
- IDLE:
  - byte_ready=0, busy=0.
  - start=1 -> HDR; error cleared, busy=1 from the next cycle.
- HDR:
  - byte_ready=1.
  - On a byte transfer, N=0 or N>NUM_WORDS -> error=1, busy=0, back to IDLE.
  - On a byte transfer with a valid N: store N, word index=0, byte count=0, checksum=0 -> COLLECT.
- COLLECT:
  - byte_ready=1.
  - Each transfer shifts the byte into the assembly register, XORs it into the checksum and increments the byte count.
  - The WIDTH/8-th transfer -> WRITE.
- WRITE:
  - Latency: write_valid=1 for exactly one cycle, in the cycle after the 4th byte's transfer.
  - write_adr = word index, zero-extended; instr_data = assembled word; byte_ready=0.
  - If word index == N-1 -> CHK; otherwise increment index, clear byte count -> COLLECT.
- CHK:
  - byte_ready=1.
  - On a byte transfer, match -> DONE.
  - On a byte transfer, mismatch -> error=1, busy=0, IDLE.
- DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- Stalls:
  - byte_valid may drop at any time and the loader waits indefinitely; there is no timeout.
  - A byte offered while byte_ready=0 is not consumed; the source holds it.
- start outside IDLE is ignored.
- Throughput: minimum 5 cycles per word.
- A header of N=NUM_WORDS writes addresses 0..NUM_WORDS-1; no write ever goes at or beyond NUM_WORDS.

Decomposition:
- Shared package instr_loader_pkg:
  - FSM state enum.
  - BYTES_PER_WORD = WIDTH/8.
  - Byte count width and word index width = $clog2(NUM_WORDS)+1.
- Sub-module instr_byte_packer:
  - Shift register plus byte counter plus running XOR checksum.
  - Inputs: shift enable and clear. Outputs: word, word_full, checksum.
  - The loader owns the FSM and the write port.

Test Plan:
1. Reset, then start, then bytes 02 8C 01 00 04 00 22 18 20 93 -> write_valid at adr 0 with instr_data 32'h8C010004, and at adr 1 with 32'h00221820; done pulses once; error=0; busy low afterwards.
2. Header 00, and separately header 21 (33) -> error=1, busy=0, no write_valid, byte_ready=0 in IDLE; a following good frame clears error.
3. Frame as in 1 but checksum 94 -> both writes occur, error=1, done never asserted.
4. Frame as in 1 with byte_valid gaps of 0-3 random cycles, and a byte presented during the WRITE cycle -> that byte is accepted next cycle; writes and data identical to 1.
5. Assert reset after the 2nd data byte of word 1 (async, mid-cycle) -> all outputs 0 immediately, no write_valid; a new start loads from adr 0 correctly.
6. Header 20 (32) with 128 data bytes (word k = 32'hA5000000+k) plus checksum -> 32 writes at adr 0..31 in order, last at adr 31, done pulse, no adr 32.
